// File: rtl/bank_op_sequencer.sv
// Register-bank operation sequencer: read two operands, hand them to the ALU, write the result back.
// Optional result timeout enabled by defining BANK_SEQ_TIMEOUT_EN.
module bank_op_sequencer #(
    parameter int DW          = 24,
    parameter int AW          = 5,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_src_a,
    input  logic [AW-1:0] cmd_src_b,
    input  logic [AW-1:0] cmd_dst,
    input  logic          cmd_wb_en,
    output logic [AW-1:0] bank_dira,
    output logic [AW-1:0] bank_dirb,
    output logic          bank_write,
    output logic [DW-1:0] bank_data,
    input  logic [DW-1:0] bank_a,
    input  logic [DW-1:0] bank_b,
    output logic          alu_valid,
    input  logic          alu_ready,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic          res_valid,
    output logic          res_ready,
    input  logic [DW-1:0] res_data,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        ISSUE    = 3'd2,
        WAIT_RES = 3'd3,
        WB       = 3'd4
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_dira;
    logic [AW-1:0] r_dirb;
    logic [AW-1:0] r_dst;
    logic          r_wb_en;
    logic          r_write;
    logic [DW-1:0] r_data;
    logic          r_alu_valid;
    logic [DW-1:0] r_alu_a;
    logic [DW-1:0] r_alu_b;
    logic          r_res_ready;
    logic          r_done;
    logic          w_alu_hs;
    logic          w_res_hs;

    assign w_alu_hs = r_alu_valid & alu_ready;
    assign w_res_hs = res_valid & r_res_ready;

`ifdef BANK_SEQ_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [CW-1:0] r_tcnt;
    logic          r_err;
    logic          w_tmo;

    assign w_tmo = (r_tcnt == CW'(TIMEOUT_CYC - 1));
    assign err   = r_err;
`else
    assign err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_dira      <= '0;
            r_dirb      <= '0;
            r_dst       <= '0;
            r_wb_en     <= 1'b0;
            r_write     <= 1'b0;
            r_data      <= '0;
            r_alu_valid <= 1'b0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_res_ready <= 1'b0;
            r_done      <= 1'b0;
`ifdef BANK_SEQ_TIMEOUT_EN
            r_tcnt      <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_done  <= 1'b0;
            r_write <= 1'b0;
`ifdef BANK_SEQ_TIMEOUT_EN
            r_err   <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_dira  <= cmd_src_a;
                        r_dirb  <= cmd_src_b;
                        r_dst   <= cmd_dst;
                        r_wb_en <= cmd_wb_en;
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    r_alu_a     <= bank_a;
                    r_alu_b     <= bank_b;
                    r_alu_valid <= 1'b1;
                    r_state     <= ISSUE;
                end
                ISSUE: begin
                    if (w_alu_hs) begin
                        r_alu_valid <= 1'b0;
                        r_res_ready <= 1'b1;
                        r_state     <= WAIT_RES;
`ifdef BANK_SEQ_TIMEOUT_EN
                        r_tcnt      <= '0;
`endif
                    end
                end
                WAIT_RES: begin
                    // dira switches to the destination only now, after operands are captured
                    if (w_res_hs) begin
                        r_res_ready <= 1'b0;
                        r_data      <= res_data;
                        r_dira      <= r_dst;
                        r_write     <= r_wb_en;
                        r_done      <= 1'b1;
                        r_state     <= WB;
                    end
`ifdef BANK_SEQ_TIMEOUT_EN
                    else if (w_tmo) begin
                        r_res_ready <= 1'b0;
                        r_err       <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
`endif
                end
                WB: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = rst_n & (r_state == IDLE);
    assign bank_dira  = r_dira;
    assign bank_dirb  = r_dirb;
    assign bank_write = r_write;
    assign bank_data  = r_data;
    assign alu_valid  = r_alu_valid;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign res_ready  = r_res_ready;
    assign done       = r_done;

endmodule
